// File: rtl/smbs_deserializer.sv
// ============================================================================
// Module   : smbs_deserializer
// Purpose  : Packs a per-bit payload stream MSB-first into channel-tagged words
//            behind a single-entry valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module smbs_deserializer #(
    parameter int WORD_W = 8,
    parameter int ADDR_W = 6,
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_in,
    input  logic              bit_valid,
    input  logic              chunk_end,
    input  logic [ADDR_W-1:0] addr,
    output logic [WORD_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic [CNT_W-1:0]  out_nbits,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow,
    output logic              bad_addr,
    input  logic              clear_err
);

    localparam logic [ADDR_W:0]  C_NUM_CH = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] C_WORD_W = CNT_W'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CH_W-1:0]   ch_q;
    logic [WORD_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [CNT_W-1:0]  out_nbits_q;
    logic              out_valid_q;
    logic              overflow_q;
    logic              bad_addr_q;

    logic              start, bad_start, collecting, shift_en;
    logic              word_full, flush, emit, can_load;
    logic [WORD_W-1:0] emit_data;
    logic [CNT_W-1:0]  emit_nbits;
    logic [CH_W-1:0]   emit_ch;

    always_comb begin
        start      = (state_q == ST_IDLE) && bit_valid;
        bad_start  = start && ({1'b0, addr} >= C_NUM_CH);
        collecting = (state_q == ST_COLLECT) || (start && !bad_start);
        shift_en   = collecting && bit_valid;

        sr_d       = shift_en ? {sr_q[WORD_W-2:0], bit_in} : sr_q;
        cnt_inc    = shift_en ? cnt_q + 1'b1 : cnt_q;
        word_full  = shift_en && (cnt_inc == C_WORD_W);
        // A chunk ending exactly on a word boundary leaves nothing to flush.
        flush      = collecting && chunk_end && !word_full && (cnt_inc != '0);
        emit       = word_full || flush;

        // The shift register is right-aligned; left-justify partial words.
        emit_data  = word_full ? sr_d : (sr_d << (C_WORD_W - cnt_inc));
        emit_nbits = word_full ? C_WORD_W : cnt_inc;
        emit_ch    = (state_q == ST_IDLE) ? addr[CH_W-1:0] : ch_q;
        can_load   = !out_valid_q || out_ready;

        cnt_d      = (word_full || (collecting && chunk_end)) ? '0 : cnt_inc;

        state_d    = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (chunk_end)      state_d = ST_IDLE;
                    else if (bad_start) state_d = ST_DISCARD;
                    else                state_d = ST_COLLECT;
                end
            end
            ST_COLLECT, ST_DISCARD: begin
                if (chunk_end) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            ch_q        <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_nbits_q <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            bad_addr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            if (start) begin
                ch_q <= addr[CH_W-1:0];
            end

            if (emit && can_load) begin
                out_data_q  <= emit_data;
                out_ch_q    <= emit_ch;
                out_nbits_q <= emit_nbits;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A new error event in the same cycle takes priority over clear.
            overflow_q <= (overflow_q && !clear_err) || (emit && !can_load);
            bad_addr_q <= (bad_addr_q && !clear_err) || bad_start;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_nbits = out_nbits_q;
    assign out_valid = out_valid_q;
    assign overflow  = overflow_q;
    assign bad_addr  = bad_addr_q;

endmodule

`default_nettype wire

// File: tb/tb_smbs_deserializer.sv
// Directed bench for smbs_deserializer: a bit-position reference model is
// compared against the DUT every cycle, alongside literal expectations.
`default_nettype none

module tb_smbs_deserializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in, bit_valid, chunk_end, out_ready, clear_err;
    logic [5:0] addr;
    logic [7:0] out_data;
    logic [1:0] out_ch;
    logic [3:0] out_nbits;
    logic       out_valid, overflow, bad_addr;

    int n_chk = 0;
    int n_err = 0;

    smbs_deserializer #(
        .WORD_W(8), .ADDR_W(6), .NUM_CH(4), .CH_W(2), .CNT_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .chunk_end(chunk_end), .addr(addr), .out_data(out_data), .out_ch(out_ch),
        .out_nbits(out_nbits), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .bad_addr(bad_addr), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: bits are placed by position within the current word.
    logic [7:0] m_acc, m_od;
    int         m_nb, m_onb;
    bit         m_inchunk, m_badchunk, m_ov, m_ovf, m_bad;
    logic [1:0] m_ch, m_och;

    always @(posedge clk or negedge rst_n) begin : model
        logic [7:0] acc, ed;
        int         nb, en;
        bit         inc, bad_c, emit, sovf, sbad;
        logic [1:0] ch;
        if (!rst_n) begin
            m_acc <= '0; m_nb <= 0; m_inchunk <= 0; m_badchunk <= 0; m_ch <= '0;
            m_od <= '0; m_onb <= 0; m_och <= '0; m_ov <= 0; m_ovf <= 0; m_bad <= 0;
        end else begin
            acc = m_acc; nb = m_nb; inc = m_inchunk; bad_c = m_badchunk; ch = m_ch;
            emit = 0; sovf = 0; sbad = 0; ed = '0; en = 0;
            if (bit_valid) begin
                if (!inc) begin
                    inc = 1; ch = addr[1:0]; bad_c = (addr >= 6'd4); sbad = bad_c;
                end
                if (!bad_c) begin
                    acc[7-nb] = bit_in;
                    nb++;
                    if (nb == 8) begin
                        emit = 1; ed = acc; en = 8; acc = '0; nb = 0;
                    end
                end
            end
            if (chunk_end && inc) begin
                if (!bad_c && nb > 0) begin
                    emit = 1; ed = acc; en = nb; acc = '0; nb = 0;
                end
                inc = 0;
            end
            if (emit) begin
                if (!m_ov || out_ready) begin
                    m_ov <= 1; m_od <= ed; m_onb <= en; m_och <= ch;
                end else begin
                    sovf = 1;
                end
            end else if (m_ov && out_ready) begin
                m_ov <= 0;
            end
            m_ovf <= (m_ovf && !clear_err) || sovf;
            m_bad <= (m_bad && !clear_err) || sbad;
            m_acc <= acc; m_nb <= nb; m_inchunk <= inc; m_badchunk <= bad_c; m_ch <= ch;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("cyc_valid", {31'b0, out_valid}, {31'b0, m_ov});
            check("cyc_overflow", {31'b0, overflow}, {31'b0, m_ovf});
            check("cyc_bad_addr", {31'b0, bad_addr}, {31'b0, m_bad});
            if (m_ov) begin
                check("cyc_data", {24'b0, out_data}, {24'b0, m_od});
                check("cyc_ch", {30'b0, out_ch}, {30'b0, m_och});
                check("cyc_nbits", {28'b0, out_nbits}, m_onb);
            end
        end
    end

    logic [7:0] xfer_q[$];
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) xfer_q.push_back(out_data);
    end

    task automatic step(input logic bv, input logic b, input logic ce);
        bit_valid = bv; bit_in = b; chunk_end = ce;
        @(negedge clk);
        bit_valid = 1'b0; bit_in = 1'b0; chunk_end = 1'b0;
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit ce_last);
        for (int i = 0; i < n; i++) step(1'b1, bits[n-1-i], ce_last && (i == n - 1));
    endtask

    initial begin
        logic [31:0] pat;
        rst_n = 1'b0; bit_in = 0; bit_valid = 0; chunk_end = 0;
        addr = '0; out_ready = 1'b1; clear_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 0);
        check("rst_data", {24'b0, out_data}, 0);
        check("rst_nbits", {28'b0, out_nbits}, 0);
        check("rst_flags", {30'b0, overflow, bad_addr}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full word at channel 2
        addr = 6'd2;
        send(32'hB2, 8, 1);
        check("full_valid", {31'b0, out_valid}, 1);
        check("full_data", {24'b0, out_data}, 32'hB2);
        check("full_ch", {30'b0, out_ch}, 2);
        check("full_nbits", {28'b0, out_nbits}, 8);
        check("model_full", {24'b0, m_od}, 32'hB2);
        step(0, 0, 0);
        check("full_drop", {31'b0, out_valid}, 0);

        // Partial flush, then a 16-bit chunk
        addr = 6'd1;
        send(32'h7, 3, 0);
        step(0, 0, 1);
        check("part_data", {24'b0, out_data}, 32'hE0);
        check("part_nbits", {28'b0, out_nbits}, 3);
        check("part_ch", {30'b0, out_ch}, 1);
        step(0, 0, 0);
        xfer_q.delete();
        send(32'h1234, 16, 1);
        repeat (2) step(0, 0, 0);
        check("c16_count", xfer_q.size(), 2);
        if (xfer_q.size() == 2) begin
            check("c16_w0", {24'b0, xfer_q[0]}, 32'h12);
            check("c16_w1", {24'b0, xfer_q[1]}, 32'h34);
        end

        // Backpressure and overflow
        out_ready = 1'b0; addr = 6'd0;
        send(32'hA53C, 16, 1);
        check("bp_data", {24'b0, out_data}, 32'hA5);
        check("bp_overflow", {31'b0, overflow}, 1);
        repeat (2) step(0, 0, 0);
        xfer_q.delete();
        out_ready = 1'b1;
        repeat (2) step(0, 0, 0);
        check("bp_count", xfer_q.size(), 1);
        if (xfer_q.size() == 1) check("bp_word", {24'b0, xfer_q[0]}, 32'hA5);
        check("bp_idle", {31'b0, out_valid}, 0);
        clear_err = 1'b1;
        step(0, 0, 0);
        clear_err = 1'b0;
        check("bp_clear", {31'b0, overflow}, 0);

        // Bad address, then set-wins-over-clear, then recovery
        addr = 6'd9;
        send(32'hFF, 8, 1);
        check("bad_flag", {31'b0, bad_addr}, 1);
        check("bad_novalid", {31'b0, out_valid}, 0);
        clear_err = 1'b1;
        step(1, 0, 1);
        clear_err = 1'b0;
        check("bad_setwins", {31'b0, bad_addr}, 1);
        clear_err = 1'b1;
        step(0, 0, 0);
        clear_err = 1'b0;
        check("bad_clear", {31'b0, bad_addr}, 0);
        addr = 6'd0;
        send(32'h5A, 8, 1);
        check("ok_data", {24'b0, out_data}, 32'h5A);
        check("ok_ch", {30'b0, out_ch}, 0);
        step(0, 0, 0);

        // Back-to-back 24 bits
        addr = 6'd3; xfer_q.delete();
        pat = 32'hC37E19;
        for (int i = 0; i < 24; i++) begin
            step(1, pat[23-i], i == 23);
            check("b2b_valid", {31'b0, out_valid}, {31'b0, (i % 8) == 7});
        end
        step(0, 0, 0);
        check("b2b_count", xfer_q.size(), 3);
        if (xfer_q.size() == 3) begin
            check("b2b_w0", {24'b0, xfer_q[0]}, 32'hC3);
            check("b2b_w1", {24'b0, xfer_q[1]}, 32'h7E);
            check("b2b_w2", {24'b0, xfer_q[2]}, 32'h19);
        end

        // Reset mid-chunk with a pending word
        out_ready = 1'b0; addr = 6'd2;
        send(32'hF0, 8, 0);
        send(32'h15, 5, 0);
        rst_n = 1'b0;
        #1;
        check("mid_valid", {31'b0, out_valid}, 0);
        check("mid_data", {24'b0, out_data}, 0);
        check("mid_ch_nb", {26'b0, out_ch, out_nbits}, 0);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1; addr = 6'd1;
        @(negedge clk);
        send(32'h81, 8, 1);
        check("mid_new_data", {24'b0, out_data}, 32'h81);
        check("mid_new_nbits", {28'b0, out_nbits}, 8);
        check("mid_new_ch", {30'b0, out_ch}, 1);
        step(0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
